// File: rtl/cnn_mac_acc_requant.sv
// ============================================================================
// Module      : cnn_mac_acc_requant
// Description : Bias-seeded product accumulator with round/saturate/ReLU
//               requantization to the ap_fixed<14,6> activation format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_mac_acc_requant #(
  parameter int PROD_W    = 22,
  parameter int PROD_FRAC = 14,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 14,
  parameter int OUT_FRAC  = 8,
  parameter int MAX_TERMS = 1024,
  parameter bit RND_EN    = 1'b1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              relu_en,
  input  logic [OUT_W-1:0]  bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              err_overrun
);

  localparam int SHIFT = PROD_FRAC - OUT_FRAC;
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  localparam logic [CNT_W-1:0]        c_cnt_max = CNT_W'(MAX_TERMS);
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_out_max = ACC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] c_out_min = ACC_W'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RQ  = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_sat;
  logic                     r_err_overrun;
  logic                     r_relu;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;

  logic                     w_beat;
  logic                     w_first;
  logic [CNT_W-1:0]         w_cnt_nx;
  logic                     w_cnt_full;
  logic signed [ACC_W-1:0]  w_bias_sh;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic [ACC_W:0]           w_sum_wide;
  logic signed [ACC_W-1:0]  w_sum_sat;
  logic signed [ACC_W-1:0]  w_rnd_src;
  logic signed [ACC_W-1:0]  w_shr;
  logic [OUT_W-1:0]         w_clamp;
  logic                     w_sat;
  logic [OUT_W-1:0]         w_result;

  // Clamp an (ACC_W+1)-bit two's-complement sum back into ACC_W bits.
  function automatic logic [ACC_W-1:0] f_sat(input logic [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1]) begin
      f_sat = v[ACC_W] ? c_acc_min : c_acc_max;
    end else begin
      f_sat = v[ACC_W-1:0];
    end
  endfunction

  assign w_beat     = in_valid && r_in_ready && (r_state == ST_ACC);
  assign w_first    = (r_count == '0);
  assign w_cnt_nx   = r_count + 1'b1;
  assign w_cnt_full = (w_cnt_nx == c_cnt_max);

  assign w_bias_sh  = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} <<< SHIFT;
  assign w_prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign w_base     = w_first ? w_bias_sh : r_acc;
  assign w_sum_wide = {w_base[ACC_W-1], w_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_sum_sat  = f_sat(w_sum_wide);

  generate
    if (RND_EN) begin : g_rnd
      localparam logic [ACC_W:0] c_half = (ACC_W+1)'(2**(SHIFT-1));
      logic [ACC_W:0] w_rnd_wide;
      assign w_rnd_wide = {r_acc[ACC_W-1], r_acc} + c_half;
      assign w_rnd_src  = f_sat(w_rnd_wide);
    end else begin : g_trunc
      assign w_rnd_src = r_acc;
    end
  endgenerate

  assign w_shr = w_rnd_src >>> SHIFT;

  always_comb begin
    w_clamp = w_shr[OUT_W-1:0];
    w_sat   = 1'b0;
    if (w_shr > c_out_max) begin
      w_clamp = c_out_max[OUT_W-1:0];
      w_sat   = 1'b1;
    end else if (w_shr < c_out_min) begin
      w_clamp = c_out_min[OUT_W-1:0];
      w_sat   = 1'b1;
    end
  end

  // ReLU acts after saturation so out_sat still reports a negative clamp.
  assign w_result = (r_relu && w_clamp[OUT_W-1]) ? '0 : w_clamp;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_beat && (in_last || w_cnt_full)) begin
          w_state_nx = ST_RQ;
        end
      end
      ST_RQ: begin
        w_state_nx = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_nx = ST_ACC;
        end
      end
      default: begin
        w_state_nx = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= ST_ACC;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_sat     <= 1'b0;
      r_err_overrun <= 1'b0;
      r_relu        <= 1'b0;
      r_acc         <= '0;
      r_count       <= '0;
    end else begin
      r_state    <= w_state_nx;
      // Registered so that ready only rises on the first edge after reset.
      r_in_ready <= (w_state_nx == ST_ACC);

      if (w_beat) begin
        r_acc   <= w_sum_sat;
        r_count <= w_cnt_nx;
        if (w_first) begin
          r_relu <= relu_en;
        end
        if (w_cnt_full && !in_last) begin
          r_err_overrun <= 1'b1;
        end
      end

      if (r_state == ST_RQ) begin
        r_out_data  <= w_result;
        r_out_sat   <= w_sat;
        r_out_valid <= 1'b1;
      end

      if ((r_state == ST_OUT) && out_ready) begin
        r_out_valid <= 1'b0;
        r_count     <= '0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sat     = r_out_sat;
  assign err_overrun = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_cnn_mac_acc_requant.sv
// ============================================================================
// Module      : tb_cnn_mac_acc_requant
// Description : Directed bench with a window-level reference model; a rounding
//               and a truncating instance run side by side on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_mac_acc_requant;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        relu_en;
  logic [13:0] bias;
  logic        in_valid;
  logic [21:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_sat,  err_overrun;
  logic [13:0] out_data;
  logic        in_ready_t, out_valid_t, out_sat_t, err_overrun_t;
  logic [13:0] out_data_t;

  int passed = 0;
  int total  = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_mac_acc_requant #(.RND_EN(1'b1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .relu_en(relu_en), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .err_overrun(err_overrun)
  );

  cnn_mac_acc_requant #(.RND_EN(1'b0)) dut_t (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .relu_en(relu_en), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .out_sat(out_sat_t), .err_overrun(err_overrun_t)
  );

  function automatic void chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
  endfunction

  // ---------------- reference model (window level) ----------------
  typedef struct {
    int dr; bit sr;   // rounding instance
    int dt; bit st;   // truncating instance
  } res_t;

  bit     m_started = 0, m_rq = 0, m_outv = 0, m_err = 0;
  bit     m_relu;
  longint m_bias;
  longint m_prods[$];
  res_t   m_res;

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void rq(input longint acc, input bit rnd, input bit relu,
                             output int d, output bit s);
    longint a, r;
    a = rnd ? sat32(acc + 32) : acc;
    r = a >>> 6;
    s = (r > 8191) || (r < -8192);
    if (r > 8191) r = 8191;
    else if (r < -8192) r = -8192;
    if (relu && r < 0) r = 0;
    d = int'(r);
  endfunction

  function automatic res_t compute(input longint b, input bit relu, input longint prods[$]);
    res_t   res;
    longint acc;
    acc = b * 64;
    foreach (prods[i]) acc = sat32(acc + prods[i]);
    rq(acc, 1'b1, relu, res.dr, res.sr);
    rq(acc, 1'b0, relu, res.dt, res.st);
    return res;
  endfunction

  always @(posedge ap_clk or negedge ap_rst_n) begin : model
    bit acc_ok;
    if (!ap_rst_n) begin
      m_started = 0; m_rq = 0; m_outv = 0; m_err = 0;
      m_prods.delete();
    end else begin
      acc_ok = m_started && !m_rq && !m_outv;
      if (m_outv && out_ready) m_outv = 0;
      if (m_rq) begin m_rq = 0; m_outv = 1; end
      if (acc_ok && in_valid) begin
        if (m_prods.size() == 0) begin
          m_bias = longint'($signed(bias));
          m_relu = relu_en;
        end
        m_prods.push_back(longint'($signed(in_prod)));
        if (in_last || m_prods.size() == 1024) begin
          if (!in_last) m_err = 1;
          m_res = compute(m_bias, m_relu, m_prods);
          m_prods.delete();
          m_rq = 1;
        end
      end
      m_started = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      chk("in_ready",      in_ready,      m_started && !m_rq && !m_outv);
      chk("in_ready_t",    in_ready_t,    m_started && !m_rq && !m_outv);
      chk("out_valid",     out_valid,     m_outv);
      chk("out_valid_t",   out_valid_t,   m_outv);
      chk("err_overrun",   err_overrun,   m_err);
      chk("err_overrun_t", err_overrun_t, m_err);
      if (m_outv) begin
        chk("out_data",   longint'($signed(out_data)),   m_res.dr);
        chk("out_sat",    out_sat,   m_res.sr);
        chk("out_data_t", longint'($signed(out_data_t)), m_res.dt);
        chk("out_sat_t",  out_sat_t, m_res.st);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input int p, input bit last);
    int t;
    in_valid = 1'b1;
    in_prod  = 22'(p);
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge ap_clk); t++; end
    if (t >= 50) chk("beat accept timeout", 0, 1);
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string nm, input int er, input bit es,
                            input int et, input bit est, output int waits);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin @(negedge ap_clk); t++; end
    waits = t;
    if (t >= 20) chk({nm, " result timeout"}, 0, 1);
    chk({nm, " data"},   longint'($signed(out_data)),   er);
    chk({nm, " sat"},    out_sat,   es);
    chk({nm, " data_t"}, longint'($signed(out_data_t)), et);
    chk({nm, " sat_t"},  out_sat_t, est);
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic set_win(input int b, input bit r);
    bias    = 14'(b);
    relu_en = r;
  endtask

  initial begin
    int w;
    ap_rst_n = 1'b0; relu_en = 1'b0; bias = '0;
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("rst in_ready",  in_ready,  0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data",  out_data,  0);
    chk("rst out_sat",   out_sat,   0);
    chk("rst err",       err_overrun, 0);
    ap_rst_n = 1'b1;
    #1 chk("ready low until edge", in_ready, 0);
    @(negedge ap_clk);
    chk("ready after edge", in_ready, 1);

    // three beats of 1.0 -> 3.0, valid two cycles after last
    set_win(0, 0);
    beat(16384, 0); beat(16384, 0); beat(16384, 1);
    get_result("t1", 768, 0, 768, 0, w);
    chk("t1 latency", w, 1);

    // rounding vs truncation at the half-LSB point
    set_win(0, 0); beat(32, 1);  get_result("t2 +half", 1, 0, 0, 0, w);
    set_win(0, 0); beat(-32, 1); get_result("t2 -half", 0, 0, -1, 0, w);

    // positive and negative saturation, ReLU behaviour
    set_win(256, 0);
    repeat (4) beat(2097151, 0);
    beat(0, 1);
    get_result("t3 possat", 8191, 1, 8191, 1, w);
    set_win(-8192, 0);
    repeat (3) beat(-2097152, 0);
    beat(-2097152, 1);
    get_result("t3 negsat", -8192, 1, -8192, 1, w);
    set_win(0, 1); beat(-16384, 1); get_result("t3 relu neg", 0, 0, 0, 0, w);
    set_win(0, 1); beat(16384, 1);  get_result("t3 relu pos", 256, 0, 256, 0, w);
    set_win(-8192, 1); repeat (2) beat(-2097152, 0); beat(0, 1);
    get_result("t3 relu sat", 0, 1, 0, 1, w);

    // back-pressure: output held, offered beats not consumed
    set_win(0, 0); beat(32768, 1);
    w = 0;
    while (!out_valid && w < 20) begin @(negedge ap_clk); w++; end
    in_valid = 1'b1; in_prod = 22'(1000); in_last = 1'b1;
    repeat (5) begin
      @(negedge ap_clk);
      chk("t4 hold data", longint'($signed(out_data)), 512);
      chk("t4 hold rdy",  in_ready, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("t4", 512, 0, 512, 0, w);
    chk("t4 ready next cycle", in_ready, 1);

    // asynchronous reset mid-window
    set_win(0, 0); beat(16384, 0); beat(16384, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t5 async in_ready",  in_ready,  0);
    chk("t5 async out_valid", out_valid, 0);
    chk("t5 async out_data",  out_data,  0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    set_win(0, 0); beat(16384, 1); get_result("t5 after rst", 256, 0, 256, 0, w);

    // overrun: MAX_TERMS beats with no last
    set_win(0, 0);
    repeat (1024) beat(0, 0);
    get_result("t6 overrun", 0, 0, 0, 0, w);
    chk("t6 err set", err_overrun, 1);
    set_win(0, 0); beat(16384, 1); get_result("t6 next", 256, 0, 256, 0, w);
    chk("t6 err sticky", err_overrun, 1);
    ap_rst_n = 1'b0;
    #1 chk("t6 err cleared", err_overrun, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
